// File: rtl/ram_arbiter_if.sv
// Request/response and RAM command bundle shared by two requesters, the arbiter and the command RAM.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req_valid0, req_valid1;
  logic                 req_we0, req_we1;
  logic [ADDR_SIZE-1:0] req_addr0, req_addr1;
  logic [ADDR_SIZE-1:0] req_wdata0, req_wdata1;
  logic                 req_ready0, req_ready1;
  logic                 rsp_valid0, rsp_valid1;
  logic [ADDR_SIZE-1:0] rsp_data;
  logic                 rsp_err;
  logic                 busy;
  logic [ADDR_SIZE+1:0] ram_din;
  logic                 ram_rx_valid;
  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;

  modport slave (
    input  req_valid0, req_valid1, req_we0, req_we1, req_addr0, req_addr1,
           req_wdata0, req_wdata1, ram_dout, ram_tx_valid,
    output req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_data, rsp_err,
           busy, ram_din, ram_rx_valid
  );

  modport master (
    output req_valid0, req_valid1, req_we0, req_we1, req_addr0, req_addr1,
           req_wdata0, req_wdata1, ram_dout, ram_tx_valid,
    input  req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_data, rsp_err,
           busy, ram_din, ram_rx_valid
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising two requesters onto the two-beat command RAM; write ack 3 cycles after accept,
// read 4 (3+TIMEOUT on timeout); req_ready only rises in IDLE, so requesters simply hold valid while busy.
module ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 4
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_RD} state_t;
  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 rsp_valid0_q, rsp_valid0_d;
  logic                 rsp_valid1_q, rsp_valid1_d;
  logic [ADDR_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 grant0, grant1;
  logic [ADDR_SIZE+1:0] ram_din_c;
  logic                 ram_rx_valid_c;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req_valid0 && bus.req_valid1) begin
        // a tie goes to whichever requester was not served last
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = bus.req_valid0;
        grant1 = bus.req_valid1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    rsp_valid0_d   = 1'b0;
    rsp_valid1_d   = 1'b0;
    rsp_data_d     = '0;
    rsp_err_d      = 1'b0;
    ram_din_c      = '0;
    ram_rx_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          we_d         = grant1 ? bus.req_we1    : bus.req_we0;
          addr_d       = grant1 ? bus.req_addr1  : bus.req_addr0;
          wdata_d      = grant1 ? bus.req_wdata1 : bus.req_wdata0;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        ram_din_c      = {(we_q ? 2'b00 : 2'b10), addr_q};
        ram_rx_valid_c = 1'b1;
        state_d        = DATA;
      end
      DATA: begin
        ram_rx_valid_c = 1'b1;
        if (we_q) begin
          ram_din_c    = {2'b01, wdata_q};
          rsp_valid0_d = ~owner_q;
          rsp_valid1_d = owner_q;
          state_d      = IDLE;
        end else begin
          ram_din_c = {2'b11, {ADDR_SIZE{1'b0}}};
          cnt_d     = '0;
          state_d   = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (bus.ram_tx_valid) begin
          rsp_valid0_d = ~owner_q;
          rsp_valid1_d = owner_q;
          rsp_data_d   = bus.ram_dout;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TIMEOUT_CNT) begin
            rsp_valid0_d = ~owner_q;
            rsp_valid1_d = owner_q;
            rsp_err_d    = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready0   = grant0;
  assign bus.req_ready1   = grant1;
  assign bus.rsp_valid0   = rsp_valid0_q;
  assign bus.rsp_valid1   = rsp_valid1_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.ram_din      = ram_din_c;
  assign bus.ram_rx_valid = ram_rx_valid_c;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural command RAM, directed vector table, hand-written corner sequences
// and random transactions checked against a shadow-memory transaction model.
module tb_ram_arbiter;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_SIZE(8)) bus ();
  ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Behavioural command RAM; ram_stub hides its read-valid to force timeouts.
  logic [7:0] ram_mem [256] = '{default: 8'h00};
  logic [7:0] ram_waddr = 8'h00;
  logic [7:0] ram_raddr = 8'h00;
  logic [7:0] ram_dout_q = 8'h00;
  logic       ram_txv = 1'b0;
  logic       ram_stub = 1'b0;

  always @(posedge clk) begin
    if (bus.ram_rx_valid) begin
      case (bus.ram_din[9:8])
        2'b00: ram_waddr <= bus.ram_din[7:0];
        2'b01: ram_mem[ram_waddr] <= bus.ram_din[7:0];
        2'b10: begin ram_raddr <= bus.ram_din[7:0]; ram_txv <= 1'b0; end
        default: begin ram_dout_q <= ram_mem[ram_raddr]; ram_txv <= 1'b1; end
      endcase
    end
  end
  assign bus.ram_dout     = ram_dout_q;
  assign bus.ram_tx_valid = ram_txv & ~ram_stub;

  // Reference memory contents as seen by completed transactions.
  logic [7:0] shadow [256] = '{default: 8'h00};

  typedef struct {
    bit         r;
    bit         we;
    bit         stub;
    logic [7:0] a;
    logic [7:0] d;
    int         exp_lat;
    logic [7:0] exp_data;
    logic       exp_err;
    logic [9:0] exp_b0;
    logic [9:0] exp_b1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid0 && bus.rsp_valid1) begin
        miscompares++;
        $display("FAIL rsp_exclusive: both rsp_valid high at %0t", $time);
      end
      if (bus.req_ready0 && bus.req_ready1) begin
        miscompares++;
        $display("FAIL ready_exclusive: both req_ready high at %0t", $time);
      end
    end
  end

  task automatic set_req(input bit r, input bit v, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (r) begin
      bus.req_valid1 = v; bus.req_we1 = we; bus.req_addr1 = a; bus.req_wdata1 = d;
    end else begin
      bus.req_valid0 = v; bus.req_we0 = we; bus.req_addr0 = a; bus.req_wdata0 = d;
    end
  endtask

  task automatic wait_ready(input bit r, input string name);
    int w = 0;
    #1;
    while (!(r ? bus.req_ready1 : bus.req_ready0) && w < 40) begin
      @(negedge clk); #1; w++;
    end
    if (w >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: req_ready%0d never rose within 40 cycles", name, r);
    end
  endtask

  // Issue one transaction, alter the request fields right after acceptance, then record beats and response.
  task automatic run_txn(input bit r, input bit we, input logic [7:0] a, input logic [7:0] d, input string name,
                         output int lat, output logic [7:0] rdata, output logic rerr, output logic rown,
                         output logic rbusy, output logic [9:0] b0, output logic [9:0] b1, output int nb);
    lat = -1; rdata = 8'h00; rerr = 1'b0; rown = 1'b0; rbusy = 1'b1; b0 = '0; b1 = '0; nb = 0;
    set_req(r, 1'b1, we, a, d);
    wait_ready(r, name);
    @(posedge clk); #1;
    set_req(r, 1'b0, we, ~a, ~d);
    for (int c = 1; c <= 30 && lat < 0; c++) begin
      @(negedge clk); #1;
      if (bus.ram_rx_valid) begin
        if (nb == 0) b0 = bus.ram_din;
        else if (nb == 1) b1 = bus.ram_din;
        nb++;
      end
      if (bus.rsp_valid0 || bus.rsp_valid1) begin
        lat = c; rdata = bus.rsp_data; rerr = bus.rsp_err; rown = bus.rsp_valid1; rbusy = bus.busy;
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat, nb;
    logic [7:0] rd;
    logic re, ro, rb;
    logic [9:0] b0, b1;
    ram_stub = v.stub;
    run_txn(v.r, v.we, v.a, v.d, tag, lat, rd, re, ro, rb, b0, b1, nb);
    ram_stub = 1'b0;
    check({tag, ".lat"},   lat, v.exp_lat);
    check({tag, ".data"},  rd, v.exp_data);
    check({tag, ".err"},   re, v.exp_err);
    check({tag, ".owner"}, ro, v.r);
    check({tag, ".busy"},  rb, 0);
    check({tag, ".beats"}, nb, 2);
    check({tag, ".b0"},    b0, v.exp_b0);
    check({tag, ".b1"},    b1, v.exp_b1);
    if (v.we) shadow[v.a] = v.d;
  endtask

  function automatic vec_t model(input bit r, input bit we, input bit stub, input logic [7:0] a, input logic [7:0] d);
    vec_t v;
    v.r = r; v.we = we; v.stub = stub && !we; v.a = a; v.d = d;
    v.exp_b0   = {(we ? 2'b00 : 2'b10), a};
    v.exp_b1   = we ? {2'b01, d} : 10'h300;
    v.exp_lat  = we ? 3 : (v.stub ? 3 + TIMEOUT : 4);
    v.exp_data = (we || v.stub) ? 8'h00 : shadow[a];
    v.exp_err  = v.stub;
    return v;
  endfunction

  vec_t tbl [8];

  initial begin
    tbl[0] = '{0, 1, 0, 8'h12, 8'hA5, 3, 8'h00, 1'b0, 10'h012, 10'h1A5};
    tbl[1] = '{0, 0, 0, 8'h12, 8'h00, 4, 8'hA5, 1'b0, 10'h212, 10'h300};
    tbl[2] = '{1, 1, 0, 8'hFF, 8'h00, 3, 8'h00, 1'b0, 10'h0FF, 10'h100};
    tbl[3] = '{1, 0, 0, 8'hFF, 8'h00, 4, 8'h00, 1'b0, 10'h2FF, 10'h300};
    tbl[4] = '{0, 1, 0, 8'h00, 8'hFF, 3, 8'h00, 1'b0, 10'h000, 10'h1FF};
    tbl[5] = '{1, 0, 0, 8'h00, 8'h00, 4, 8'hFF, 1'b0, 10'h200, 10'h300};
    tbl[6] = '{0, 0, 1, 8'h12, 8'h00, 7, 8'h00, 1'b1, 10'h212, 10'h300};
    tbl[7] = '{1, 0, 0, 8'h12, 8'h00, 4, 8'hA5, 1'b0, 10'h212, 10'h300};

    // Reset state, with both requesters already asserting a tie.
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h80, 8'h11);
    set_req(1, 1'b1, 1'b1, 8'h81, 8'h22);
    repeat (2) @(negedge clk);
    #1;
    check("reset.busy", bus.busy, 0);
    check("reset.rsp_valid0", bus.rsp_valid0, 0);
    check("reset.rsp_valid1", bus.rsp_valid1, 0);
    check("reset.rsp_data", bus.rsp_data, 0);
    check("reset.rsp_err", bus.rsp_err, 0);
    check("reset.ram_din", bus.ram_din, 0);
    check("reset.ram_rx_valid", bus.ram_rx_valid, 0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    begin
      int gq[$];
      int gcyc[$];
      int ngr = 0;
      int c = 0;
      while (c < 40 && (ngr < 4 || gq.size() > 0)) begin
        check("tie.ready_excl", bus.req_ready0 & bus.req_ready1, 0);
        if (bus.rsp_valid0 || bus.rsp_valid1) begin
          if (gq.size() == 0) check("tie.spurious_rsp", 1, 0);
          else check("tie.rsp_owner", bus.rsp_valid1, gq.pop_front());
        end
        if (ngr < 4 && (bus.req_ready0 || bus.req_ready1)) begin
          check("tie.grant", bus.req_ready1, ngr % 2);
          gq.push_back(ngr % 2);
          gcyc.push_back(c);
          ngr++;
          if (ngr == 4) begin
            @(posedge clk); #1;
            bus.req_valid0 = 1'b0;
            bus.req_valid1 = 1'b0;
          end
        end
        @(negedge clk); #1;
        c++;
      end
      check("tie.grants", ngr, 4);
      check("tie.rsp_drain", gq.size(), 0);
      for (int i = 1; i < gcyc.size(); i++) check("tie.spacing", gcyc[i] - gcyc[i-1], 3);
      shadow[8'h80] = 8'h11;
      shadow[8'h81] = 8'h22;
    end

    for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Busy hold-off: requester 1 arrives while requester 0's read sits in WAIT_RD.
    set_req(0, 1'b1, 1'b0, 8'h12, 8'h00);
    wait_ready(0, "hold.accept0");
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    set_req(1, 1'b1, 1'b1, 8'h55, 8'h66);
    #1;
    check("hold.ready1_low", bus.req_ready1, 0);
    check("hold.busy", bus.busy, 1);
    @(negedge clk); #1;
    check("hold.rsp_valid0", bus.rsp_valid0, 1);
    check("hold.rsp_data", bus.rsp_data, shadow[8'h12]);
    check("hold.ready1_high", bus.req_ready1, 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b1, 8'h00, 8'h00);
    @(negedge clk); #1;
    check("hold.addr_beat", bus.ram_din, 10'h055);
    check("hold.rx_valid", bus.ram_rx_valid, 1);
    repeat (2) @(negedge clk);
    #1;
    check("hold.rsp_valid1", bus.rsp_valid1, 1);
    shadow[8'h55] = 8'h66;
    @(negedge clk); #1;

    // Reset during the DATA beat of a write must leave the previous contents intact.
    apply(model(0, 1'b1, 1'b0, 8'h40, 8'h3C), "rst.prewrite");
    set_req(0, 1'b1, 1'b1, 8'h40, 8'hC3);
    wait_ready(0, "rst.accept");
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b1, 8'h00, 8'h00);
    @(negedge clk); #1;
    check("rst.addr_beat", bus.ram_din, 10'h040);
    @(posedge clk); #2;
    check("rst.data_beat", bus.ram_din, 10'h1C3);
    rst = 1'b1;
    #1;
    check("rst.ram_din", bus.ram_din, 0);
    check("rst.rx_valid", bus.ram_rx_valid, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.rsp_valid0", bus.rsp_valid0, 0);
    check("rst.rsp_data", bus.rsp_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    begin
      int nrsp = 0;
      for (int c = 0; c < 6; c++) begin
        if (bus.rsp_valid0 || bus.rsp_valid1) nrsp++;
        @(negedge clk); #1;
      end
      check("rst.no_rsp", nrsp, 0);
    end
    apply('{0, 0, 0, 8'h40, 8'h00, 4, 8'h3C, 1'b0, 10'h240, 10'h300}, "rst.readback");

    // Random transactions against the shadow-memory model.
    for (int i = 0; i < 40; i++) begin
      bit r, we, stub;
      logic [7:0] a, d;
      r    = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      stub = ($urandom_range(0, 5) == 0);
      a    = 8'($urandom_range(0, 15));
      d    = 8'($urandom);
      apply(model(r, we, stub, a, d), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and command sequencer for the single-port command RAM. Each requester issues whole read or write transactions. The block serialises them into the RAM's two-beat opcode protocol on `ram_din`/`ram_rx_valid`: 00 set write address, 01 write data, 10 set read address, 11 read. It then returns read data or a write acknowledge to the owning requester.

## Interface
- `ADDR_SIZE`, 8, RAM address and data width; the RAM command word is `ADDR_SIZE+2` bits.
- `TIMEOUT`, 4, maximum cycles spent in WAIT_RD before a read is failed; legal range 1..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid0`, `req_valid1`  in  1 each  transaction request.
- `req_we0`, `req_we1`  in  1 each  1 = write, 0 = read.
- `req_addr0`, `req_addr1`  in  ADDR_SIZE each  RAM address.
- `req_wdata0`, `req_wdata1`  in  ADDR_SIZE each  write data; ignored for reads.
- `req_ready0`, `req_ready1`  out  1 each  request accepted this cycle.
- `rsp_valid0`, `rsp_valid1`  out  1 each  one-cycle completion pulse to the owning requester.
- `rsp_data`  out  ADDR_SIZE  read data; 0 for writes and errors.
- `rsp_err`  out  1  read timed out; valid with `rsp_valid*`.
- `busy`  out  1  high in every state except IDLE.
- `ram_din`  out  ADDR_SIZE+2  command word: opcode in `[ADDR_SIZE+1:ADDR_SIZE]`, payload in `[ADDR_SIZE-1:0]`.
- `ram_rx_valid`  out  1  command strobe to RAM.
- `ram_dout`  in  ADDR_SIZE  RAM read data.
- `ram_tx_valid`  in  1  RAM read data valid.

## Operation
- FSM states: IDLE, ADDR, DATA, WAIT_RD.
- **Arbitration** (IDLE only):
  - Grant is the single requester with `req_valid` high.
  - If both are high, grant the requester not named by `last_grant`. `last_grant` resets to 1, so requester 0 wins the first tie.
  - `req_readyN` is a combinational grant: high only in IDLE for the granted N.
- **Acceptance:** on handshake (`req_validN` & `req_readyN`):
  - latch owner, we, addr and wdata;
  - set `last_grant`=N;
  - go to ADDR.
- **ADDR:** `ram_din`={we?00:10, addr}, `ram_rx_valid`=1 → DATA.
- **DATA, write:** `ram_din`={01, wdata}, `ram_rx_valid`=1 → IDLE. Register next cycle `rsp_validN`=1, `rsp_data`=0, `rsp_err`=0.
- **DATA, read:** `ram_din`={11, 0}, `ram_rx_valid`=1 → WAIT_RD, timeout counter cleared.
- **WAIT_RD:**
  - If `ram_tx_valid`=1: register next cycle `rsp_data`=`ram_dout`, `rsp_validN`=1, `rsp_err`=0; go to IDLE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: register next cycle `rsp_validN`=1, `rsp_err`=1, `rsp_data`=0; go to IDLE.
- **Outside ADDR and DATA:** `ram_din`=0, `ram_rx_valid`=0.
- RAM-side outputs are decoded from registered state only; there is no input-to-RAM combinational path.
- Requests arriving while busy wait; `req_ready` stays low.
- Inputs are latched at acceptance; later changes to `req_*` have no effect on the transaction in flight.

## Timing
- **Reset values (async, immediate):**
  - state=IDLE, `last_grant`=1, counter=0;
  - `rsp_valid0/1`=0, `rsp_data`=0, `rsp_err`=0;
  - `ram_din`=0, `ram_rx_valid`=0, `busy`=0.
- **Write:** accept at cycle T; ADDR at T+1; DATA at T+2; `rsp_valid` at T+3.
- **Read:** accept at T; ADDR at T+1; DATA at T+2; WAIT_RD at T+3, where the RAM registers `tx_valid`; `rsp_valid` at T+4.
- **Read timeout:** `rsp_valid` with `rsp_err` at T+3+TIMEOUT.
- **Back-to-back:** the next acceptance is possible in the same cycle `rsp_valid` is high (IDLE). Write-to-write throughput is 1 transaction per 3 cycles.
- **Stale data:** `ram_tx_valid` from a previous read is never sampled outside WAIT_RD. The ADDR beat of any new read clears it in the RAM first.
- **Reset mid-transaction:**
  - the transaction is abandoned and no `rsp_valid` is issued;
  - a write aborted after ADDR leaves only the RAM write address changed; memory contents are untouched.
- `rsp_valid0` and `rsp_valid1` are never high together.

## Test plan
- **Write then read:** requester 0 writes addr 0x12, data 0xA5; then reads 0x12. Required:
  - `ram_din` sequence 0x012, 0x1A5, 0x212, 0x300;
  - write ack `rsp_valid0` at T+3;
  - read returns `rsp_data`=0xA5, `rsp_err`=0, at T+4.
- **Tie:** both requesters hold `req_valid` from reset. Required:
  - grants alternate 0,1,0,1;
  - `req_ready` never high for both;
  - each `rsp_validN` matches its owner.
- **Timeout:** read with `ram_tx_valid` held 0 (RAM stubbed), TIMEOUT=4. Required: `rsp_valid`, `rsp_err`=1, `rsp_data`=0 at T+7; FSM back in IDLE.
- **Reset mid-transaction:** assert `rst` during DATA of a write to 0x40. Required:
  - all outputs are immediately at reset values;
  - no `rsp_valid` is issued;
  - a subsequent read of 0x40 returns its prior contents.
- **Busy hold-off:** requester 1 raises `req_valid` while requester 0's read is in WAIT_RD. Required: `req_ready1` stays 0 until IDLE, then requester 1 is accepted in the cycle `rsp_valid0` pulses.
- **Input stability:** change `req_addr0`/`req_wdata0` the cycle after acceptance. Required: `ram_din` carries the originally latched values.
